// File: rtl/trg_pkg.sv
// Shared widths, constants and the match-window helper for trg_match_ctrl.
// Per-channel match counters exist only when TRG_MATCH_CNT_EN is defined.
package trg_pkg;

    localparam int unsigned WIN_W      = 3;
    localparam int unsigned HIST_LEN   = 7;
    localparam int unsigned PUSH_DLY_W = 5;
    localparam int unsigned CNT_W      = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    typedef logic [HIST_LEN-1:0] win_mask_t;

    // Low W bits set; a programmed window of 0 behaves as a window of 1.
    function automatic win_mask_t win_mask(input logic [WIN_W-1:0] win);
        logic [WIN_W-1:0]  w_eff;
        logic [HIST_LEN:0] ones;
        w_eff = (win == '0) ? WIN_W'(1) : win;
        ones  = ((HIST_LEN+1)'(1) << w_eff) - (HIST_LEN+1)'(1);
        return ones[HIST_LEN-1:0];
    endfunction

endpackage

// File: rtl/trg_match_ctrl_lct_chan.sv
// One trigger channel: latency ring buffer, match window with once-only clearing,
// push delay line and, with TRG_MATCH_CNT_EN defined, a saturating match counter.
module lct_chan
    import trg_pkg::*;
#(
    parameter int unsigned DLY_W = 7
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  lct_i,
    input  logic                  l1a_i,
    input  logic [DLY_W-1:0]      wp_i,
    input  logic [DLY_W-1:0]      rp_i,
    input  logic                  bypass_i,
    input  logic                  rd_ok_i,
    input  win_mask_t             wmask_i,
    input  logic [PUSH_DLY_W-1:0] push_dly_i,
    input  logic                  cnt_clr_i,
    output logic                  match_o,
    output logic                  push_o,
    output logic [CNT_W-1:0]      cnt_o
);

    localparam int unsigned DEPTH  = 1 << DLY_W;
    localparam int unsigned SH_LEN = (1 << PUSH_DLY_W) - 1;

    logic                mem_q [DEPTH];
    logic                d_lct_q;
    logic [HIST_LEN-2:0] hist_q;
    logic [HIST_LEN-2:0] hist_d;
    logic [HIST_LEN-1:0] hist_now;
    logic                match;
    logic                match_q;
    logic [SH_LEN-1:0]   sh_q;
    logic [SH_LEN:0]     push_tap;

    // Buffer contents are deliberately not reset; the fill guard masks stale data.
    always_ff @(posedge CLK) begin
        mem_q[wp_i] <= lct_i;
    end

    // Clearing the window bits on a match stops a later L1A re-using the same LCT,
    // while an LCT arriving on the following cycle enters bit 0 untouched.
    always_comb begin
        hist_now = {hist_q, d_lct_q};
        match    = l1a_i & |(hist_now & wmask_i);
        hist_d   = hist_now[HIST_LEN-2:0];
        if (match) begin
            hist_d = hist_now[HIST_LEN-2:0] & ~wmask_i[HIST_LEN-2:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            d_lct_q <= 1'b0;
            hist_q  <= '0;
            match_q <= 1'b0;
            sh_q    <= '0;
        end else begin
            d_lct_q <= bypass_i ? lct_i : (rd_ok_i & mem_q[rp_i]);
            hist_q  <= hist_d;
            match_q <= match;
            sh_q    <= {sh_q[SH_LEN-2:0], match_q};
        end
    end

    assign push_tap = {sh_q, match_q};
    assign push_o   = push_tap[push_dly_i];
    assign match_o  = match_q;

`ifdef TRG_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if (match_q && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign cnt_o          = '0;
`endif

endmodule

// File: rtl/trg_match_ctrl.sv
// DMB trigger control: input mux/kill, LCTERR, shared delay pointers, N_CH match channels.
// Define TRG_MATCH_CNT_EN to build per-channel match counters and the CNT_OUT readout.
module trg_match_ctrl
    import trg_pkg::*;
#(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned DLY_W = 7
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [N_CH-1:0]           PRE_LCT_IN,
    input  logic                      L1A_IN,
    input  logic                      CAL_MODE,
    input  logic [N_CH-2:0]           CAL_STRIP,
    input  logic [N_CH-1:0]           KILL_MASK,
    input  logic [DLY_W-1:0]          L1LATNCY,
    input  logic [WIN_W-1:0]          WIN,
    input  logic [PUSH_DLY_W-1:0]     PUSH_DLY,
    input  logic                      CNT_CLR,
    input  logic [$clog2(N_CH)-1:0]   CNT_SEL,
    output logic [N_CH-1:0]           L1A_MATCH,
    output logic [N_CH-1:0]           PUSH,
    output logic                      LCTERR,
    output logic [CNT_W-1:0]          CNT_OUT
);

    localparam int unsigned SEL_W = $clog2(N_CH);
    localparam logic [DLY_W:0] FILL_FULL = {1'b1, {DLY_W{1'b0}}};

    logic [N_CH-1:0]             lct_d;
    logic [N_CH-1:0]             lct_q;
    logic                        l1a_q;
    logic                        l1a_al_q;
    logic                        lcterr_q;
    logic [DLY_W-1:0]            wp_q;
    logic [DLY_W:0]              fill_q;
    logic [DLY_W-1:0]            rp;
    logic                        rd_ok;
    logic                        bypass;
    win_mask_t                   wmask;
    logic [N_CH-1:0][CNT_W-1:0]  cnt_w;

    always_comb begin
        lct_d = (CAL_MODE ? {CAL_STRIP, |CAL_STRIP} : PRE_LCT_IN) & ~KILL_MASK;
    end

    // The buffer read is registered, so L1A gets one extra stage to stay aligned with it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            lct_q    <= '0;
            l1a_q    <= 1'b0;
            l1a_al_q <= 1'b0;
            lcterr_q <= 1'b0;
            wp_q     <= '0;
            fill_q   <= '0;
        end else begin
            lct_q    <= lct_d;
            l1a_q    <= L1A_IN;
            l1a_al_q <= l1a_q;
            lcterr_q <= lct_q[0] ^ (|lct_q[N_CH-1:1]);
            wp_q     <= wp_q + 1'b1;
            if (fill_q != FILL_FULL) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    assign rp     = wp_q - L1LATNCY;
    assign rd_ok  = fill_q >= {1'b0, L1LATNCY};
    assign bypass = (L1LATNCY == '0);
    assign wmask  = win_mask(WIN);
    assign LCTERR = lcterr_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        lct_chan #(
            .DLY_W (DLY_W)
        ) u_chan (
            .CLK        (CLK),
            .RST_N      (RST_N),
            .lct_i      (lct_q[g]),
            .l1a_i      (l1a_al_q),
            .wp_i       (wp_q),
            .rp_i       (rp),
            .bypass_i   (bypass),
            .rd_ok_i    (rd_ok),
            .wmask_i    (wmask),
            .push_dly_i (PUSH_DLY),
            .cnt_clr_i  (CNT_CLR),
            .match_o    (L1A_MATCH[g]),
            .push_o     (PUSH[g]),
            .cnt_o      (cnt_w[g])
        );
    end

`ifdef TRG_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_out_q;
    logic             sel_ok;

    if ((1 << SEL_W) > N_CH) begin : g_sel_chk
        assign sel_ok = (32'(CNT_SEL) < N_CH);
    end else begin : g_sel_all
        assign sel_ok = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_out_q <= '0;
        end else begin
            cnt_out_q <= sel_ok ? cnt_w[CNT_SEL] : '0;
        end
    end

    assign CNT_OUT = cnt_out_q;
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^{CNT_SEL, cnt_w};
    assign CNT_OUT        = '0;
`endif

endmodule

// File: doc/trg_match_ctrl.md
# trg_match_ctrl

Parametrised next-generation trigger control for the DMB: accepts N_CH pre-LCT lines (channel 0 = ALCT/OR, 1..N_CH-1 = DCFEBs), applies kill/calibration overrides, delays each channel by a programmable L1 latency, matches the delayed LCTs against L1A within a programmable window, and issues per-channel push pulses after a programmable push delay. Sits between the front-panel trigger inputs and the FIFO write control. Adds deeper latency buffering, variable match window, once-only matching and optional per-channel match counters.

## Interface
- N_CH, 8, channel count (channel 0 plus N_CH-1 DCFEBs), 2..16
- DLY_W, 7, latency field width; delay buffer depth 2^DLY_W
- CLK  in  1  system clock (40 MHz bunch-crossing clock)
- RST_N  in  1  reset, synchronous, active-low
- PRE_LCT_IN  in  N_CH  raw pre-LCT per channel
- L1A_IN  in  1  level-1 accept, active-high
- CAL_MODE  in  1  calibration override enable
- CAL_STRIP  in  N_CH-1  calibration pattern for channels 1..N_CH-1
- KILL_MASK  in  N_CH  1 = channel forced to 0
- L1LATNCY  in  DLY_W  LCT delay L, 0..2^DLY_W-1
- WIN  in  3  match window W in cycles; 0 treated as 1
- PUSH_DLY  in  5  push delay P, 0..31
- CNT_CLR  in  1  clear all match counters
- CNT_SEL  in  $clog2(N_CH)  counter readout select
- L1A_MATCH  out  N_CH  one-cycle match pulse per channel
- PUSH  out  N_CH  one-cycle push pulse per channel
- LCTERR  out  1  channel-0 / DCFEB-OR disagreement
- CNT_OUT  out  16  selected match counter

## Operation
- Input mux: CAL_MODE=1 → ch[N_CH-1:1]=CAL_STRIP, ch0=|CAL_STRIP; else PRE_LCT_IN. Then AND with ~KILL_MASK. Result registered (lct_r); L1A_IN registered (l1a_r).
- LCTERR registered: lct_r[0] ^ |lct_r[N_CH-1:1].
- Delay: per-channel ring buffer, depth 2^DLY_W, shared write pointer incrementing every cycle (wraps at 2^DLY_W-1→0); read address = wp−L mod 2^DLY_W; L=0 bypasses buffer (d_lct = lct_r).
- Fill guard: reset clears wp and a fill counter (saturates at 2^DLY_W); d_lct forced 0 while fill < L. Buffer RAM is not cleared.
- Window: per-channel history hist[6:0] of d_lct (bit 0 = current). Match[i] = l1a_r & |hist[i][W-1:0].
- Once-only: on match, hist[i][W-1:0] cleared next cycle; a second L1A in the same window does not match the same LCT. New d_lct on the same cycle as clearing is retained.
- L1A_MATCH registered from match. PUSH = L1A_MATCH delayed P cycles (32-bit shift per channel; P=0 → PUSH = L1A_MATCH). Overlapping pending pushes all delivered.
- L1LATNCY/WIN/PUSH_DLY changes take effect next cycle, no flush; events in flight may be lost or duplicated (software retunes only with triggers off).
- Reset: all outputs 0, hist/shift regs/pointers/counters 0.

## Timing
- PRE_LCT_IN high at edge e0 (kill/cal inactive) → LCTERR valid after e0+1.
- d_lct high during cycle after edge e0+L+1; L1A_IN sampled at edge e0+L+j, 0≤j≤W-1 → L1A_MATCH high for one cycle after edge e0+L+j+2.
- PUSH high one cycle after edge e0+L+j+2+P.
- RST_N low at any edge: state cleared at that edge, pending pushes dropped.

## Configuration
- TRG_MATCH_CNT_EN defined: per-channel 16-bit saturating counters increment on L1A_MATCH[i]; CNT_CLR sync-clears all (clear wins over simultaneous increment); CNT_OUT = cnt[CNT_SEL] registered, 0 if CNT_SEL ≥ N_CH.
- Undefined: no counters; CNT_OUT tied 0, CNT_CLR/CNT_SEL ignored.

## Structure
- Package trg_pkg: WIN_W=3, HIST_LEN=7, PUSH_DLY_W=5, CNT_W=16, CNT_MAX=16'hFFFF.
- Sub-module lct_chan: one channel's ring buffer, fill-masked read, history/once-only clearing, push shift register, optional counter; instantiated N_CH times by generate. Top holds input mux, kill, LCTERR, shared wp/fill counter, readout mux.

## Test plan
- L=10, W=1, P=0, pulse ch3 at e0, L1A at e0+10 → L1A_MATCH[3] after e0+12, PUSH[3] same cycle; no other bits.
- L=10, W=3, two L1As at e0+10 and e0+11 → one match only; third L1A at e0+13 → no match.
- CAL_MODE=1, CAL_STRIP=0x05, KILL_MASK=0x02 → ch0 and ch3 delayed, ch1 killed; LCTERR=0; KILL_MASK=0x01 → LCTERR=1.
- L=127, reset then immediate LCT/L1A within 127 cycles → no match; after fill, L1A at e0+127 → match; verifies wrap at wp 127→0.
- P=31, L1As matching on consecutive cycles → PUSH pulses 31 cycles later, none lost; RST_N low mid-delay → no PUSH.
- With TRG_MATCH_CNT_EN: 70000 matches on ch0 → CNT_OUT=0xFFFF (CNT_SEL=0); CNT_CLR coincident with match → 0.
